// File: rtl/encoder.sv
// encoder: inverts, PN15-randomizes, I/Q-multiplexes, NRZ-M/S and Biphase-L
// encodes a serial NRZ-L stream for the modulator.
// Latency: enc_i/enc_q/cout update on the clk edge that accepts the (second) bit.
// Backpressure: none; the block pulls one bit per strobe and encodes a fill 0 if data_valid is low.
//
// Optional feature: `define ENCODER_TEST_PATTERN_EN adds an internal PN15 test source (test_pat).
//
// Ports:
//   clk, rs            clock; synchronous active-low reset
//   symb_clk_en        symbol-rate strobe
//   symb_clk_2x_en     2x symbol-rate strobe, coincides with every symb_clk_en
//   data_in/valid      source bit and its qualifier
//   data_ready         bit-accept strobe (combinational)
//   mode               00/11 NRZ-L, 01 NRZ-M, 10 NRZ-S
//   biphase, demux     Biphase-L on I (wins over demux) / QPSK bit pairing
//   swap               in demux, the first bit of a pair goes to Q
//   randomize          enable the PN15 randomizer
//   data_inv           invert source bits
//   test_pat           internal PN15 source select (test-pattern build only)
//   stat_clr           clears underflow
//   enc_i, enc_q, cout encoded channel bits and their update strobe
//   underflow          sticky: a strobe happened with no valid data
module encoder (
  input  logic       clk,
  input  logic       rs,
  input  logic       symb_clk_en,
  input  logic       symb_clk_2x_en,
  input  logic       data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [1:0] mode,
  input  logic       biphase,
  input  logic       demux,
  input  logic       swap,
  input  logic       randomize,
  input  logic       data_inv,
  input  logic       test_pat,
  input  logic       stat_clr,
  output logic       enc_i,
  output logic       enc_q,
  output logic       cout,
  output logic       underflow
);

  logic [14:0] pn_s;      // randomizer shift register
  logic        p_i, p_q;  // per-channel differential state
  logic        phase;     // biphase chip phase
  logic        bph_m;     // biphase: encoded bit held for the second chip
  logic        pair_reg;  // demux: first bit of the pending pair

  logic strobe, src_bit, uf_set, b, r;
  logic ch_i_bit, ch_q_bit;
  logic e_ser, e_i_dmx, e_q_dmx;

  // Differential encoder: NRZ-M flips on 1, NRZ-S flips on 0.
  function automatic logic diff_enc(input logic p, input logic d, input logic [1:0] m);
    case (m)
      2'b01:   diff_enc = p ^ d;
      2'b10:   diff_enc = p ^ ~d;
      default: diff_enc = d;
    endcase
  endfunction

  // Bit-accept strobe; in biphase only the first chip of a symbol takes a bit.
  always_comb begin
    if (biphase)    strobe = symb_clk_en & ~phase;
    else if (demux) strobe = symb_clk_2x_en;
    else            strobe = symb_clk_en;
  end

  assign data_ready = strobe & rs;

`ifdef ENCODER_TEST_PATTERN_EN
  logic [14:0] tp_s;
  logic        tp_bit;

  assign tp_bit  = tp_s[14] ^ tp_s[13];
  assign src_bit = test_pat ? tp_bit : (data_valid & data_in);
  assign uf_set  = strobe & ~test_pat & ~data_valid;

  always_ff @(posedge clk) begin
    if (!rs)
      tp_s <= 15'h7FFF;
    else if (strobe && test_pat)
      tp_s <= {tp_s[13:0], tp_bit};
  end
`else
  logic unused_test_pat;

  assign unused_test_pat = test_pat;
  assign src_bit         = data_valid & data_in;
  assign uf_set          = strobe & ~data_valid;
`endif

  // Randomizer feeds back its own output, so the decoder can self-synchronize.
  assign b = src_bit ^ data_inv;
  assign r = randomize ? (b ^ pn_s[14] ^ pn_s[13]) : b;

  assign ch_i_bit = swap ? r : pair_reg;
  assign ch_q_bit = swap ? pair_reg : r;
  assign e_ser    = diff_enc(p_i, r, mode);
  assign e_i_dmx  = diff_enc(p_i, ch_i_bit, mode);
  assign e_q_dmx  = diff_enc(p_q, ch_q_bit, mode);

  always_ff @(posedge clk) begin
    if (!rs) begin
      enc_i     <= 1'b0;
      enc_q     <= 1'b0;
      cout      <= 1'b0;
      underflow <= 1'b0;
      pn_s      <= '0;
      p_i       <= 1'b0;
      p_q       <= 1'b0;
      phase     <= 1'b0;
      bph_m     <= 1'b0;
      pair_reg  <= 1'b0;
    end else begin
      cout <= 1'b0;

      if (stat_clr) underflow <= 1'b0;
      if (uf_set)   underflow <= 1'b1;

      if (strobe && randomize)
        pn_s <= {pn_s[13:0], r};

      if (biphase) begin
        if (symb_clk_en) begin
          phase    <= ~phase;
          cout     <= 1'b1;
          enc_q    <= 1'b0;
          pair_reg <= 1'b0;
          if (!phase) begin
            enc_i <= e_ser;
            bph_m <= e_ser;
            p_i   <= e_ser;
          end else begin
            enc_i <= ~bph_m;
          end
        end
      end else if (demux) begin
        if (symb_clk_2x_en) begin
          if (!symb_clk_en) begin
            pair_reg <= r;
          end else begin
            enc_i    <= e_i_dmx;
            enc_q    <= e_q_dmx;
            p_i      <= e_i_dmx;
            p_q      <= e_q_dmx;
            pair_reg <= 1'b0;
            phase    <= 1'b0;
            cout     <= 1'b1;
          end
        end
      end else if (symb_clk_en) begin
        // Serial: Q carries I delayed by one symbol. A pending pair is dropped.
        enc_i    <= e_ser;
        enc_q    <= enc_i;
        p_i      <= e_ser;
        pair_reg <= 1'b0;
        phase    <= 1'b0;
        cout     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed scoreboard bench for encoder.
// Latency: checks each output one clk after its accepting strobe.
// Backpressure: n/a (bench drives one strobe every three clks).
module tb_encoder;

  logic       clk;
  logic       rs;
  logic       symb_clk_en;
  logic       symb_clk_2x_en;
  logic       data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] mode;
  logic       biphase;
  logic       demux;
  logic       swap;
  logic       randomize;
  logic       data_inv;
  logic       test_pat;
  logic       stat_clr;
  logic       enc_i;
  logic       enc_q;
  logic       cout;
  logic       underflow;

  encoder dut (
    .clk            (clk),
    .rs             (rs),
    .symb_clk_en    (symb_clk_en),
    .symb_clk_2x_en (symb_clk_2x_en),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .mode           (mode),
    .biphase        (biphase),
    .demux          (demux),
    .swap           (swap),
    .randomize      (randomize),
    .data_inv       (data_inv),
    .test_pat       (test_pat),
    .stat_clr       (stat_clr),
    .enc_i          (enc_i),
    .enc_q          (enc_q),
    .cout           (cout),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dec=1: ei is the expected bit after NRZ-M decode + derandomize of enc_i.
  // dec=0: ei/eq are the expected channel bits; eq only checked when cq=1.
  typedef struct packed {
    logic dec;
    logic ei;
    logic eq;
    logic cq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Output monitor: samples at negedge, pops one expectation per cout pulse.
  logic        prev_e;
  logic [14:0] ds;
  logic        rr, dd;
  exp_t        ent;

  always @(negedge clk) begin
    if (!rs) begin
      prev_e = 1'b0;
      ds     = '0;
    end else if (cout) begin
      if (sb.size() == 0) begin
        chk("unexpected_cout", 1'b1, 1'b0);
      end else begin
        ent = sb.pop_front();
        if (ent.dec) begin
          rr     = enc_i ^ prev_e;
          dd     = rr ^ ds[14] ^ ds[13];
          ds     = {ds[13:0], rr};
          prev_e = enc_i;
          chk("loopback_bit", dd, ent.ei);
        end else begin
          chk("enc_i", enc_i, ent.ei);
          if (ent.cq) chk("enc_q", enc_q, ent.eq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe clk (2x always, symb_clk_en if se) followed by two idle clks.
  task automatic strobe(input logic se, input logic d, input logic v, input logic clr,
                        input logic exp_rdy, input logic push, input exp_t e);
    symb_clk_en    = se;
    symb_clk_2x_en = 1'b1;
    data_in        = d;
    data_valid     = v;
    stat_clr       = clr;
    #1;
    chk("data_ready", data_ready, exp_rdy);
    if (push) sb.push_back(e);
    tick();
    symb_clk_en    = 1'b0;
    symb_clk_2x_en = 1'b0;
    data_valid     = 1'b0;
    stat_clr       = 1'b0;
    tick();
    tick();
  endtask

  task automatic ser(input logic d, input logic ei, input logic eq);
    strobe(1'b1, d, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, ei, eq, 1'b1}));
  endtask

  task automatic do_reset();
    rs = 1'b0;
    tick();
    tick();
    rs = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] t1_d, t2m_d, t2m_e;
  logic       rb;

  initial begin
    rs = 1'b0; symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0; data_in = 1'b0;
    data_valid = 1'b0; mode = 2'b00; biphase = 1'b0; demux = 1'b0; swap = 1'b0;
    randomize = 1'b0; data_inv = 1'b0; test_pat = 1'b0; stat_clr = 1'b0;

    // Reset state, strobes high while in reset.
    tick();
    symb_clk_en = 1'b1; symb_clk_2x_en = 1'b1; data_valid = 1'b1;
    tick();
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_enc_i", enc_i, 1'b0);
    chk("rst_enc_q", enc_q, 1'b0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0; data_valid = 1'b0;
    rs = 1'b1;
    tick();

    // NRZ-L serial: 1,0,1,1 -> I 1,0,1,1 ; Q = I one symbol late.
    t1_d = 4'b1101;  // bit k = k-th data bit
    ser(t1_d[0], 1'b1, 1'b0);
    ser(t1_d[1], 1'b0, 1'b1);
    ser(t1_d[2], 1'b1, 1'b0);
    ser(t1_d[3], 1'b1, 1'b1);

    // NRZ-M from reset: 1,1,0,1 -> 1,0,0,1.
    do_reset();
    mode  = 2'b01;
    t2m_d = 4'b1011;
    t2m_e = 4'b1001;
    ser(t2m_d[0], t2m_e[0], 1'b0);
    ser(t2m_d[1], t2m_e[1], 1'b1);
    ser(t2m_d[2], t2m_e[2], 1'b0);
    ser(t2m_d[3], t2m_e[3], 1'b0);

    // NRZ-S from reset: 0,0,1 -> 1,0,0.
    do_reset();
    mode = 2'b10;
    ser(1'b0, 1'b1, 1'b0);
    ser(1'b0, 1'b0, 1'b1);
    ser(1'b1, 1'b0, 1'b0);

    // Biphase NRZ-L: 1,0 -> chips 1,0,0,1; ready only on first chip.
    do_reset();
    mode = 2'b00; biphase = 1'b1;
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b1, 1'b0, 1'b1}));
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_t'({1'b0, 1'b0, 1'b0, 1'b1}));
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b0, 1'b1}));
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_t'({1'b0, 1'b1, 1'b0, 1'b1}));
    chk("bph_underflow", underflow, 1'b0);

    // Randomizer impulse: 1 then 14 zeros -> 1, 13 zeros, 1.
    do_reset();
    biphase = 1'b0; randomize = 1'b1;
    ser(1'b1, 1'b1, 1'b0);
    ser(1'b0, 1'b0, 1'b1);
    for (int k = 3; k <= 14; k++) ser(1'b0, 1'b0, 1'b0);
    ser(1'b0, 1'b1, 1'b0);

    // Demux pairs 1,0 with swap=0 then swap=1.
    do_reset();
    randomize = 1'b0; demux = 1'b1; swap = 1'b0;
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, exp_t'(4'b0));
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b1, 1'b0, 1'b1}));
    swap = 1'b1;
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, exp_t'(4'b0));
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b1, 1'b1}));

    // Loopback: NRZ-M + randomize + invert, decoded and derandomized by the monitor.
    do_reset();
    demux = 1'b0; swap = 1'b0; mode = 2'b01; randomize = 1'b1; data_inv = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rb = 1'($urandom_range(0, 1));
      strobe(1'b1, rb, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b1, ~rb, 1'b0, 1'b0}));
    end

    // Underflow: fill 0, sticky, clear, set-wins-over-clear.
    do_reset();
    mode = 2'b00; randomize = 1'b0; data_inv = 1'b0;
    ser(1'b1, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b1, 1'b1}));
    chk("uf_set", underflow, 1'b1);
    ser(1'b1, 1'b1, 1'b0);
    chk("uf_sticky", underflow, 1'b1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("uf_clr", underflow, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b1, 1'b1}));
    chk("uf_set_wins", underflow, 1'b1);
    ser(1'b1, 1'b1, 1'b0);

    // Mid-pair reset: first bit latched, then reset drops it.
    demux = 1'b1;
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, exp_t'(4'b0));
    rs = 1'b0; symb_clk_en = 1'b1; symb_clk_2x_en = 1'b1; data_valid = 1'b1;
    #1;
    chk("midrst_data_ready", data_ready, 1'b0);
    tick();
    chk("midrst_enc_i", enc_i, 1'b0);
    chk("midrst_enc_q", enc_q, 1'b0);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_underflow", underflow, 1'b0);
    symb_clk_en = 1'b0; symb_clk_2x_en = 1'b0; data_valid = 1'b0;
    rs = 1'b1;
    tick();
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b1, 1'b1}));

    repeat (4) tick();
    chk("scoreboard_drained", (sb.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
